// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Watches NCH level inputs for edges, keeps one pending event per channel,
// and serves them round-robin through a single valid/ready output register.
//
// Handshake: evt_valid/evt_chan/evt_rising form one event. The event
// transfers on a rising clk edge where evt_valid && evt_ready. While
// evt_valid is high and evt_ready is low, evt_chan and evt_rising hold.
// evt_valid never depends combinationally on evt_ready.

module edge_event_arbiter #(
    parameter int NCH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           sig_in,
    input  logic                     cfg_we,
    input  logic [2*NCH-1:0]         cfg_mode,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(NCH)-1:0]   evt_chan,
    output logic                     evt_rising,
    output logic [NCH-1:0]           overflow,
    input  logic                     ovf_clr
);

    localparam int CW = $clog2(NCH);

    // Registered state
    logic [NCH-1:0]   r_prev;     // last sampled sig_in
    logic             r_armed;    // edge detection enabled
    logic [2*NCH-1:0] r_mode;     // per-channel mode: bit0 rise, bit1 fall
    logic [NCH-1:0]   r_pend;     // one pending event per channel
    logic [NCH-1:0]   r_pol;      // polarity of the pending event
    logic [CW-1:0]    r_ptr;      // round-robin start position

    // Combinational results
    logic [NCH-1:0]   w_qual;     // qualifying edge this cycle
    logic             w_found;    // some channel is pending
    logic [CW-1:0]    w_win;      // winning channel
    logic             w_win_pol;  // polarity stored for the winner
    logic             w_load;     // output register takes a new event
    logic [CW-1:0]    w_ptr_next;
    logic [NCH-1:0]   w_pend_nx;
    logic [NCH-1:0]   w_pol_nx;
    logic [NCH-1:0]   w_ovf_set;

    // Edge detection against the previous sample, gated by arming and mode
    always_comb begin
        w_qual = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_armed && (sig_in[i] != r_prev[i])) begin
                w_qual[i] = sig_in[i] ? r_mode[2*i] : r_mode[2*i+1];
            end
        end
    end

    // Round-robin search: first pending channel at or after r_ptr, wrapping
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_win     = '0;
        w_win_pol = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!w_found && r_pend[idx]) begin
                w_found   = 1'b1;
                w_win     = CW'(idx);
                w_win_pol = r_pol[idx];
            end
        end
        w_load     = (!evt_valid || evt_ready) && w_found;
        w_ptr_next = (w_win == CW'(NCH - 1)) ? '0 : w_win + 1'b1;
    end

    // Pending bookkeeping: grant clears, new edges set, collisions overflow,
    // and a channel switched off by a config write drops its pending event
    always_comb begin
        logic grant;
        grant     = 1'b0;
        w_pend_nx = r_pend;
        w_pol_nx  = r_pol;
        w_ovf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            grant = w_load && (w_win == CW'(i));
            if (w_qual[i]) begin
                if (r_pend[i] && !grant) begin
                    // Older event is kept; the new one is lost
                    w_ovf_set[i] = 1'b1;
                end else begin
                    w_pend_nx[i] = 1'b1;
                    w_pol_nx[i]  = sig_in[i];
                end
            end else if (grant) begin
                w_pend_nx[i] = 1'b0;
            end
            // The granted event is already headed for the output register,
            // so clearing pending here never removes a delivered event.
            if (cfg_we && (cfg_mode[2*i +: 2] == 2'b00)) begin
                w_pend_nx[i] = 1'b0;
            end
        end
    end

    // Input sampling, arming and configuration register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
            r_mode  <= '0;
        end else begin
            r_prev  <= sig_in;
            r_armed <= 1'b1;
            if (cfg_we) begin
                r_mode <= cfg_mode;
            end
        end
    end

    // Pending state and sticky overflow flags (a new set beats a clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= '0;
            r_pol    <= '0;
            overflow <= '0;
        end else begin
            r_pend   <= w_pend_nx;
            r_pol    <= w_pol_nx;
            overflow <= (ovf_clr ? '0 : overflow) | w_ovf_set;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_chan   <= '0;
            evt_rising <= 1'b0;
            r_ptr      <= '0;
        end else if (w_load) begin
            evt_valid  <= 1'b1;
            evt_chan   <= w_win;
            evt_rising <= w_win_pol;
            r_ptr      <= w_ptr_next;
        end else if (evt_ready) begin
            evt_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed testbench for edge_event_arbiter (NCH = 4).
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, i.e. they show the state produced by the edge just taken.

module tb_edge_event_arbiter;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  sig_in = '0;
    logic            cfg_we = 1'b0;
    logic [2*NCH-1:0] cfg_mode = '0;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [CW-1:0]   evt_chan;
    logic            evt_rising;
    logic [NCH-1:0]  overflow;
    logic            ovf_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] acc_q[$];   // events accepted by the consumer
    logic [7:0] exp_q[$];   // events the test expects, in order

    edge_event_arbiter #(.NCH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .cfg_we     (cfg_we),
        .cfg_mode   (cfg_mode),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_chan   (evt_chan),
        .evt_rising (evt_rising),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    // Clock
    always #5 clk = ~clk;

    // Handshake monitor: values are stable here and are the ones the next
    // rising edge will act on
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            acc_q.push_back({5'b0, evt_chan, evt_rising});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ev(input int ch, input bit rising);
        return 8'(ch * 2 + int'(rising));
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare accepted events against the expected queue, then clear both
    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, acc_q.size(), exp_q.size());
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d", tag, i), acc_q[i], exp_q[i]);
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    // Reset for two cycles, check reset state, then take the arming edge
    task automatic do_reset(input string tag);
        rst     = 1'b1;
        cfg_we  = 1'b0;
        ovf_clr = 1'b0;
        tick(2);
        check({tag, "_rst_valid"},  evt_valid,  0);
        check({tag, "_rst_chan"},   evt_chan,   0);
        check({tag, "_rst_rising"}, evt_rising, 0);
        check({tag, "_rst_ovf"},    overflow,   0);
        rst = 1'b0;
        tick(1);
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic write_cfg(input logic [2*NCH-1:0] m);
        cfg_we   = 1'b1;
        cfg_mode = m;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    initial begin
        // ---------------- armed start ----------------
        evt_ready = 1'b1;
        sig_in    = 4'b0001;
        do_reset("t1");
        write_cfg(8'h01);              // ch0 rise only
        tick(3);
        check("t1_no_evt_after_arm", evt_valid, 0);
        sig_in = 4'b0000;              // falling, not enabled
        tick(2);
        check("t1_fall_ignored", evt_valid, 0);
        sig_in = 4'b0001;              // rising
        tick(1);
        check("t1_lat_k", evt_valid, 0);
        tick(1);
        check("t1_valid", evt_valid, 1);
        check("t1_chan", evt_chan, 0);
        check("t1_rising", evt_rising, 1);
        tick(3);
        exp_q.push_back(ev(0, 1));
        check_events("t1");

        // ---------------- round robin ----------------
        evt_ready = 1'b1;
        sig_in    = 4'b0000;
        do_reset("t2");
        write_cfg(8'hFF);
        sig_in = 4'b1111;
        tick(1);
        check("t2_lat_k", evt_valid, 0);
        for (int c = 0; c < NCH; c++) begin
            tick(1);
            check($sformatf("t2_valid%0d", c), evt_valid, 1);
            check($sformatf("t2_chan%0d", c), evt_chan, c);
            check($sformatf("t2_rising%0d", c), evt_rising, 1);
        end
        tick(1);
        check("t2_drained", evt_valid, 0);
        for (int c = 0; c < NCH; c++) exp_q.push_back(ev(c, 1));
        check_events("t2");

        // ---------------- backpressure ----------------
        evt_ready = 1'b0;
        sig_in    = 4'b0000;
        do_reset("t3");
        write_cfg(8'hFF);
        sig_in = 4'b0100;              // ch2 rising -> presented
        tick(2);
        check("t3_valid", evt_valid, 1);
        check("t3_chan", evt_chan, 2);
        sig_in = 4'b0000;              // ch2 falling -> pending
        tick(1);
        check("t3_no_ovf_yet", overflow, 4'b0000);
        sig_in = 4'b0100;              // ch2 rising while pending -> lost
        tick(1);
        check("t3_ovf", overflow, 4'b0100);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("t3_hold_valid%0d", c), evt_valid, 1);
            check($sformatf("t3_hold_chan%0d", c), evt_chan, 2);
            check($sformatf("t3_hold_rising%0d", c), evt_rising, 1);
        end
        evt_ready = 1'b1;
        tick(4);
        exp_q.push_back(ev(2, 1));
        exp_q.push_back(ev(2, 0));     // pending kept its older polarity
        check_events("t3");
        check("t3_ovf_sticky", overflow, 4'b0100);

        // ---------------- grant collision ----------------
        evt_ready = 1'b1;
        sig_in    = 4'b0000;
        do_reset("t4");
        write_cfg(8'hFF);
        sig_in = 4'b0010;              // ch1 rising -> pending
        tick(1);
        sig_in = 4'b0000;              // ch1 falling in its grant cycle
        tick(1);
        check("t4_chan", evt_chan, 1);
        tick(4);
        exp_q.push_back(ev(1, 1));
        exp_q.push_back(ev(1, 0));
        check_events("t4");
        check("t4_no_ovf", overflow, 4'b0000);

        // ---------------- config clear and ovf_clr ----------------
        evt_ready = 1'b0;
        sig_in    = 4'b0000;
        do_reset("t5");
        write_cfg(8'hFF);
        sig_in = 4'b1001;              // ch0 and ch3 rising
        tick(2);
        check("t5_chan0", evt_chan, 0);
        write_cfg(8'h3F);              // ch3 off while pending
        evt_ready = 1'b1;
        tick(4);
        exp_q.push_back(ev(0, 1));
        check_events("t5_cfg");
        evt_ready = 1'b0;
        sig_in = 4'b1000;              // ch0 falling
        tick(2);
        check("t5_pres_valid", evt_valid, 1);
        check("t5_pres_rising", evt_rising, 0);
        sig_in = 4'b1001;              // ch0 rising -> pending
        tick(1);
        sig_in = 4'b1000;              // ch0 falling -> overflow
        tick(1);
        check("t5_ovf_set", overflow, 4'b0001);
        sig_in  = 4'b1001;             // new overflow with ovf_clr
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_set_beats_clr", overflow, 4'b0001);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_clr", overflow, 4'b0000);
        evt_ready = 1'b1;
        tick(4);
        exp_q.push_back(ev(0, 0));
        exp_q.push_back(ev(0, 1));
        check_events("t5_ovf");

        // ---------------- reset mid-stream ----------------
        evt_ready = 1'b0;
        sig_in    = 4'b0000;
        do_reset("t6");
        write_cfg(8'hFF);
        sig_in = 4'b1111;
        tick(2);                       // ch0 presented, three pending
        sig_in = 4'b1101;              // ch1 edge while pending
        tick(1);
        check("t6_pre_valid", evt_valid, 1);
        check("t6_pre_ovf", overflow, 4'b0010);
        rst       = 1'b1;
        evt_ready = 1'b1;
        tick(1);
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_ovf", overflow, 4'b0000);
        rst = 1'b0;
        tick(1);
        write_cfg(8'hFF);
        tick(5);
        check("t6_no_stale", evt_valid, 0);
        check_events("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
